mic_capture_ctrl: RTL
=====================

// Module: mic_capture_ctrl
// PURPOSE
//  Sequences the PDM mic front end (pdm_clk_gen + pdm_mic) for the equalizer: enables mic clocking,
//  discards post-enable settling samples, frames PCM into fixed-length blocks, buffers them and hands
//  them to the EQ datapath over valid/ready. Sits between pdm_mic.pcm_data and the filter/FFT stage.
// PARAMETERS
//  DATA_W          32    PCM sample width (matches pdm_mic.pcm_data), two's complement
//  SETTLE_SAMPLES  4096  valid samples discarded after each start (>=1)
//  FRAME_LEN       256   samples per frame; out_last marks final sample (>=2)
//  FIFO_DEPTH      16    output buffer entries, power of two (>=2)
// PORTS
//  clk             in   1       system clock (same clk as pdm_mic)
//  rst             in   1       synchronous, active-high reset
//  start           in   1       pulse: begin capture session (honoured in IDLE only)
//  stop            in   1       pulse: end session at next frame boundary
//  pcm_data        in   DATA_W  sample from pdm_mic
//  pcm_data_valid  in   1       one-cycle strobe per sample
//  mic_en          out  1       enables pdm_clk_gen / pdm_mic clocking
//  out_data        out  DATA_W  buffered sample to EQ
//  out_valid       out  1       out_data valid
//  out_last        out  1       out_data is last sample of a frame
//  out_ready       in   1       downstream accepts when out_valid&&out_ready
//  busy            out  1       state != IDLE
//  overrun         out  1       sticky: a captured sample was dropped (FIFO full)
//  clip_count      out  16      saturating count of clipped samples (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, FIFO emptied, all outputs 0, counters 0. rst mid-session aborts immediately.
//  FSM: IDLE -> WARMUP -> CAPTURE -> FINISH -> FLUSH -> IDLE.
//   IDLE:    mic_en=0. start&&!stop -> WARMUP, clears overrun, clip_count, settle/frame counters.
//            start&&stop same cycle: stay IDLE. start outside IDLE ignored.
//   WARMUP:  mic_en=1; each pcm_data_valid increments settle_cnt, sample discarded. Valid with
//            settle_cnt==SETTLE_SAMPLES-1 -> CAPTURE. stop -> IDLE directly (nothing queued).
//   CAPTURE: each pcm_data_valid pushed with last=(frame_cnt==FRAME_LEN-1); frame_cnt wraps to 0.
//            stop with frame_cnt==0 -> FLUSH; else -> FINISH. stop coincident with the pushing of a
//            last sample -> FLUSH.
//   FINISH:  as CAPTURE, stop ignored; push of last sample -> FLUSH.
//   FLUSH:   mic_en=0, further pcm_data_valid ignored; FIFO empty -> IDLE.
//  Full: full evaluated before same-cycle pop; valid while full -> sample dropped, overrun<=1,
//   frame_cnt NOT advanced (frames always exactly FRAME_LEN delivered samples).
//  Output: out_valid = FIFO non-empty; out_data/out_last stable while out_valid&&!out_ready.
//   Latency: sample pushed in cycle t into empty FIFO -> out_valid in cycle t+1. Order preserved.
//  busy=0 only in IDLE; FIFO is always empty in IDLE.
// CONFIGURATION
//  MIC_CLIP_DETECT_EN defined: each pushed sample equal to signed max or min of DATA_W increments
//   clip_count (saturates at 16'hFFFF; cleared on accepted start). Dropped samples not counted.
//  Not defined: clip_count tied to 0, no detection logic.
// STRUCTURE
//  Package mic_pkg: typedef enum logic [2:0] cap_state_t {IDLE,WARMUP,CAPTURE,FINISH,FLUSH};
//   typedef struct packed {logic last; logic [DATA_W-1:0] data;} pcm_word_t (DATA_W as pkg const).
//  Sub-module pcm_fifo: synchronous FIFO of pcm_word_t, DEPTH param, push/pop/full/empty, registered out.
// TESTING (SETTLE_SAMPLES=4, FRAME_LEN=8, FIFO_DEPTH=4, pcm_data_valid every 10 cycles)
//  1 start, 12 samples 1..12, out_ready=1 -> 1..4 dropped; 5..12 output, out_last only on 12, mic_en=1.
//  2 out_ready=0 in CAPTURE, 6 samples 5..10 -> 5..8 buffered, overrun=1; ready=1 -> 5,6,7,8 in order.
//  3 stop after 3 captured samples -> 5 more captured, out_last on 8th, mic_en=0 next cycle,
//    busy=0 one cycle after FIFO drains.
//  4 rst during CAPTURE with 2 queued -> next cycle out_valid=0, mic_en=0, busy=0, overrun=0.
//  5 start&&stop same cycle in IDLE -> mic_en stays 0; stop in WARMUP -> IDLE, no out_valid ever.
//  6 MIC_CLIP_DETECT_EN: captured 32'h7FFF_FFFF, 32'h8000_0000, 32'h0 -> clip_count=2; undefined -> 0.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared types for the PDM mic capture path: FSM state encoding and the FIFO word layout.
// Build option MIC_CLIP_DETECT_EN (see mic_capture_ctrl) uses is_clip() below.
package mic_pkg;

  localparam int MIC_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    CAPTURE,
    FINISH,
    FLUSH
  } cap_state_t;

  typedef struct packed {
    logic                  last;
    logic [MIC_DATA_W-1:0] data;
  } pcm_word_t;

  // A sample pinned at either rail of the two's complement range counts as clipped.
  function automatic logic is_clip(input logic [MIC_DATA_W-1:0] s);
    return (s == {1'b0, {(MIC_DATA_W-1){1'b1}}}) || (s == {1'b1, {(MIC_DATA_W-1){1'b0}}});
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous show-ahead FIFO of pcm_word_t; push while full is dropped, full is judged
// before any same-cycle pop. DEPTH must be a power of two (pointers wrap naturally).
module pcm_fifo
  import mic_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  pcm_word_t din_i,
  input  logic      pop_i,
  output pcm_word_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pcm_word_t     mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mic_capture_ctrl.sv
// Sequences the PDM mic front end: warm-up discard, framing into FRAME_LEN blocks, buffering to EQ.
// Define MIC_CLIP_DETECT_EN to count clipped captured samples on clip_count_o (tied to 0 otherwise).
module mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int SETTLE_SAMPLES = 4096,
  parameter int FRAME_LEN      = 256,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [MIC_DATA_W-1:0] pcm_data_i,
  input  logic                  pcm_data_valid_i,
  output logic                  mic_en_o,
  output logic [MIC_DATA_W-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           clip_count_o
);

  localparam int SW = $clog2(SETTLE_SAMPLES + 1);
  localparam int FW = $clog2(FRAME_LEN);

  cap_state_t    state_q;
  logic [SW-1:0] settleCnt_q;
  logic [FW-1:0] frameCnt_q;
  logic          micEn_q;
  logic          busy_q;
  logic          overrun_q;

  logic          capturing;
  logic          sampleIn;
  logic          accepted;
  logic          lastSample;
  logic          startOk;
  pcm_word_t     pushWord;
  pcm_word_t     fifoDout;
  logic          fifoFull;
  logic          fifoEmpty;

  assign capturing  = (state_q == CAPTURE) || (state_q == FINISH);
  assign sampleIn   = capturing && pcm_data_valid_i;
  assign accepted   = sampleIn && !fifoFull;
  assign lastSample = (frameCnt_q == FW'(FRAME_LEN - 1));
  assign startOk    = (state_q == IDLE) && start_i && !stop_i;
  assign pushWord   = '{last: lastSample, data: pcm_data_i};

  pcm_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (sampleIn),
    .din_i   (pushWord),
    .pop_i   (out_ready_i),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Dropped samples never advance frameCnt_q, so every delivered frame is exactly FRAME_LEN long.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      frameCnt_q  <= '0;
      micEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startOk) begin
            state_q     <= WARMUP;
            settleCnt_q <= '0;
            frameCnt_q  <= '0;
            overrun_q   <= 1'b0;
            micEn_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        WARMUP: begin
          if (stop_i) begin
            state_q <= IDLE;
            micEn_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (pcm_data_valid_i) begin
            if (settleCnt_q == SW'(SETTLE_SAMPLES - 1)) begin
              state_q <= CAPTURE;
            end else begin
              settleCnt_q <= settleCnt_q + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (stop_i) begin
            if ((accepted && lastSample) || (!accepted && frameCnt_q == '0)) begin
              state_q <= FLUSH;
              micEn_q <= 1'b0;
            end else begin
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          if (accepted && lastSample) begin
            state_q <= FLUSH;
            micEn_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (fifoEmpty) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          micEn_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      if (accepted) begin
        frameCnt_q <= lastSample ? '0 : frameCnt_q + 1'b1;
      end
      if (sampleIn && fifoFull) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef MIC_CLIP_DETECT_EN
  logic [15:0] clipCnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || startOk) begin
      clipCnt_q <= '0;
    end else if (accepted && is_clip(pcm_data_i) && clipCnt_q != 16'hFFFF) begin
      clipCnt_q <= clipCnt_q + 1'b1;
    end
  end

  assign clip_count_o = clipCnt_q;
`else
  assign clip_count_o = '0;
`endif

  assign mic_en_o    = micEn_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
  assign out_valid_o = !fifoEmpty;
  assign out_data_o  = fifoEmpty ? '0 : fifoDout.data;
  assign out_last_o  = !fifoEmpty && fifoDout.last;

endmodule
